seq_shift_add_mult: RTL and testbench
=====================================

Name: seq_shift_add_mult

Overview:
Parametrised sequential multiplier and successor to the fixed 4x4 combinational array multiplier. It multiplies two WIDTH-bit operands, unsigned or two's-complement selectable per operation, using one shift-add step per clock. A valid/ready handshake sits on both sides, so the block can be placed between the Tiny Tapeout pin wrapper and downstream logic with backpressure.

Parameters:
WIDTH, 4, operand width in bits (legal 2..16). The product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH+1), width of the step counter (derived; do not override).

Ports:
clk  in  1  system clock, all state rising-edge
rst_n  in  1  asynchronous, active-low reset
clr  in  1  synchronous abort; returns to IDLE, drops any in-flight or held result
in_valid  in  1  operands are valid
in_ready  out  1  block can accept operands
a  in  WIDTH  multiplicand
b  in  WIDTH  multiplier
signed_mode  in  1  1 = treat a and b as two's complement; sampled at accept
out_valid  out  1  product is valid
out_ready  in  1  consumer accepts product
product  out  2*WIDTH  result
busy  out  1  high in CALC or DONE

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, in_ready=1, out_valid=0, busy=0, product=0, counter=0, internal registers 0.
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid & in_ready at edge k:
  - Latch |a| and |b| (magnitudes if signed_mode, raw values otherwise).
  - Latch neg = signed_mode & (a[W-1] ^ b[W-1]).
  - Clear the accumulator, load counter=WIDTH, go to CALC.
- CALC: in_ready=0. Each edge:
  - If multiplier LSB = 1, add the multiplicand into the upper half of the 2W+1-bit accumulator.
  - Shift the accumulator and multiplier right by 1, decrement the counter.
  - The edge at which the counter goes 1->0 loads product (negated if neg) and moves to DONE.
  - out_valid is therefore first visible after edge k+WIDTH. Latency is WIDTH cycles from accept.
- DONE: out_valid=1; product and out_valid stay stable while out_ready=0. On out_valid & out_ready go to IDLE; out_valid deasserts next cycle. product keeps its last value until the next load.
- No overlap: in_ready is low in CALC and DONE. Minimum initiation interval is WIDTH+2 cycles (accept, WIDTH steps, handshake).
- Magnitude edge case: the most negative value (-2^(W-1)) has magnitude 2^(W-1). This fits in W unsigned bits, so there is no overflow. (-2^(W-1))^2 = 2^(2W-2) is representable in 2W signed bits.
- Zero operands still take the full WIDTH cycles. There is no early termination.
- clr has priority over every transition. Next state is IDLE, out_valid=0, product is cleared to 0.
- rst_n asserted mid-CALC or in DONE: immediate return to the reset state; the result is lost.
- signed_mode, a and b are ignored outside the accept cycle.
- in_valid held high during CALC/DONE: no effect; the operands are accepted only after the return to IDLE.

Decomposition:
- Package mult_pkg: state enum (IDLE, CALC, DONE), a function for 2's-complement magnitude, and the WIDTH bounds constants.
- One natural sub-module: shift_add_step. It is combinational, one accumulate+shift step of 2W+1 bits, instantiated once in the datapath.
- The FSM, counter and handshake stay in the top module.

Test Plan:
- WIDTH=4, unsigned, a=15, b=15, out_ready=1 -> out_valid after 4 edges, product=0xE1 (225), in_ready back high 1 cycle after the handshake.
- WIDTH=4, signed: a=-3 (0xD), b=5 -> product=0xF1 (-15). a=-8, b=-8 -> product=0x40 (64). a=-8, b=7 -> 0xC8 (-56).
- Backpressure: a=6, b=7 unsigned, out_ready=0 for 10 cycles -> product=0x2A held stable with out_valid=1 and in_ready=0 throughout; released on the first cycle out_ready=1.
- Abort: rst_n pulsed low at CALC step 2 -> out_valid=0, product=0, in_ready=1 immediately; the next operation, 3*4, gives 0x0C. Repeat using clr -> same result, taking effect at the next edge.
- Exhaustive WIDTH=4: all 256 operand pairs x both modes, streamed with random in_valid/out_ready gaps -> every product matches the reference model; transaction count in equals count out.
- WIDTH=8: 255*255 unsigned -> 0xFE01 after 8 cycles. -128*-128 signed -> 0x4000. -1*1 signed -> 0xFFFF.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

    // Legal operand widths for the multiplier.
    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 16;

    // Controller states: waiting for operands, stepping, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement magnitude of a zero-extended operand. Callers keep only
    // the low WIDTH bits, so the most negative value maps to 2^(WIDTH-1).
    function automatic logic [MAX_WIDTH-1:0] twos_magnitude(
        input logic [MAX_WIDTH-1:0] value,
        input logic                 is_negative
    );
        logic [MAX_WIDTH-1:0] result;
        result = value;
        if (is_negative) begin
            result = ~value + 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/shift_add_step.sv
// One combinational accumulate-and-shift step of the 2W+1-bit accumulator.
module shift_add_step #(
    parameter int WIDTH = 4
) (
    input  logic [2*WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0]   i_mcand,
    input  logic               i_addEn,
    output logic [2*WIDTH:0]   o_acc
);

    logic [WIDTH:0]   w_addend;
    logic [WIDTH:0]   w_upperSum;
    logic [2*WIDTH:0] w_added;

    // Conditionally add the multiplicand into the upper half, then shift right;
    // the upper half keeps one spare bit so the add can never overflow.
    always_comb begin
        w_addend   = '0;
        if (i_addEn) begin
            w_addend = {1'b0, i_mcand};
        end
        w_upperSum = i_acc[2*WIDTH:WIDTH] + w_addend;
        w_added    = {w_upperSum, i_acc[WIDTH-1:0]};
        o_acc      = w_added >> 1;
    end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier, unsigned or signed per operation, with
// valid/ready handshakes on operands and product. One step per clock.
module seq_shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int AW = 2 * WIDTH + 1;

    state_t            r_state;
    state_t            w_nextState;

    logic [WIDTH-1:0]  r_mcand;
    logic [WIDTH-1:0]  r_mplr;
    logic [AW-1:0]     r_acc;
    logic              r_neg;
    logic [CNT_W-1:0]  r_count;
    logic [PW-1:0]     r_product;

    logic              w_accept;
    logic              w_lastStep;
    logic              w_aNeg;
    logic              w_bNeg;
    logic [WIDTH-1:0]  w_magA;
    logic [WIDTH-1:0]  w_magB;
    logic [AW-1:0]     w_accNext;
    logic [PW-1:0]     w_productRaw;
    logic [PW-1:0]     w_productFinal;
    logic              w_inReady;
    logic              w_outValid;
    logic              w_busy;

    // Operand magnitudes; in unsigned mode the sign flags are forced low so
    // the raw operands pass straight through.
    always_comb begin
        w_aNeg = signed_mode & a[WIDTH-1];
        w_bNeg = signed_mode & b[WIDTH-1];
        w_magA = WIDTH'(twos_magnitude(MAX_WIDTH'(a), w_aNeg));
        w_magB = WIDTH'(twos_magnitude(MAX_WIDTH'(b), w_bNeg));
    end

    shift_add_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .i_acc   (r_acc),
        .i_mcand (r_mcand),
        .i_addEn (r_mplr[0]),
        .o_acc   (w_accNext)
    );

    // Final product from the accumulator after the last step, sign restored.
    always_comb begin
        w_productRaw   = w_accNext[PW-1:0];
        w_productFinal = w_productRaw;
        if (r_neg) begin
            w_productFinal = ~w_productRaw + 1'b1;
        end
    end

    // State register; reset drops everything back to IDLE immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and handshake outputs; clr overrides every transition.
    always_comb begin
        w_nextState = r_state;
        w_inReady   = 1'b0;
        w_outValid  = 1'b0;
        w_busy      = 1'b0;
        w_accept    = 1'b0;
        w_lastStep  = 1'b0;
        case (r_state)
            IDLE: begin
                w_inReady = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_nextState = CALC;
                end
            end
            CALC: begin
                w_busy = 1'b1;
                if (r_count == CNT_W'(1)) begin
                    w_lastStep  = 1'b1;
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_busy     = 1'b1;
                w_outValid = 1'b1;
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        if (clr) begin
            w_nextState = IDLE;
            w_accept    = 1'b0;
            w_lastStep  = 1'b0;
        end
    end

    // Datapath: load magnitudes on accept, step once per CALC cycle, and
    // capture the signed product on the final step. clr wipes held results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_acc     <= '0;
            r_neg     <= 1'b0;
            r_count   <= '0;
            r_product <= '0;
        end else if (clr) begin
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_acc     <= '0;
            r_neg     <= 1'b0;
            r_count   <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand   <= w_magA;
            r_mplr    <= w_magB;
            r_acc     <= '0;
            r_neg     <= w_aNeg ^ w_bNeg;
            r_count   <= CNT_W'(WIDTH);
        end else if (r_state == CALC) begin
            r_acc     <= w_accNext;
            r_mplr    <= r_mplr >> 1;
            r_count   <= r_count - 1'b1;
            if (w_lastStep) begin
                r_product <= w_productFinal;
            end
        end
    end

    assign in_ready  = w_inReady;
    assign out_valid = w_outValid;
    assign busy      = w_busy;
    assign product   = r_product;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult at WIDTH=4 and WIDTH=8.
module tb_seq_shift_add_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN;
    logic        clr;

    logic        inValid4, inReady4, signedMode4, outValid4, outReady4, busy4;
    logic [3:0]  a4, b4;
    logic [7:0]  product4;

    logic        inValid8, inReady8, signedMode8, outValid8, outReady8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    int checks = 0;
    int errors = 0;

    seq_shift_add_mult #(.WIDTH(4)) u_dut4 (
        .clk         (clk),
        .rst_n       (rstN),
        .clr         (clr),
        .in_valid    (inValid4),
        .in_ready    (inReady4),
        .a           (a4),
        .b           (b4),
        .signed_mode (signedMode4),
        .out_valid   (outValid4),
        .out_ready   (outReady4),
        .product     (product4),
        .busy        (busy4)
    );

    seq_shift_add_mult #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .rst_n       (rstN),
        .clr         (clr),
        .in_valid    (inValid8),
        .in_ready    (inReady8),
        .a           (a8),
        .b           (b8),
        .signed_mode (signedMode8),
        .out_valid   (outValid8),
        .out_ready   (outReady8),
        .product     (product8),
        .busy        (busy8)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sm;
        logic [7:0] expected;
    } vec_t;

    vec_t vecs[9];

    // Reference: interpret operands as integers and multiply, keep 2w bits.
    function automatic logic [31:0] refProduct(int w, logic [15:0] av, logic [15:0] bv, bit sm);
        longint x, y, p;
        x = longint'(av);
        y = longint'(bv);
        if (sm && av[w-1]) x = x - (longint'(1) << w);
        if (sm && bv[w-1]) y = y - (longint'(1) << w);
        p = x * y;
        return 32'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one WIDTH=4 operation with out_ready high; returns product and latency.
    task automatic applyStimulus4(input logic [3:0] aIn, input logic [3:0] bIn, input logic sm,
                                  output logic [7:0] prod, output int lat);
        int n;
        a4 = aIn; b4 = bIn; signedMode4 = sm; inValid4 = 1'b1; outReady4 = 1'b1;
        n = 0;
        while (!inReady4 && n < 50) begin tick(); n++; end
        tick();
        inValid4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); signedMode4 = 1'($urandom);
        lat = 0;
        while (!outValid4 && lat < 50) begin tick(); lat++; end
        prod = product4;
        tick();
    endtask

    // Same for the WIDTH=8 instance.
    task automatic applyStimulus8(input logic [7:0] aIn, input logic [7:0] bIn, input logic sm,
                                  output logic [15:0] prod, output int lat);
        int n;
        a8 = aIn; b8 = bIn; signedMode8 = sm; inValid8 = 1'b1; outReady8 = 1'b1;
        n = 0;
        while (!inReady8 && n < 50) begin tick(); n++; end
        tick();
        inValid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0;
        while (!outValid8 && lat < 50) begin tick(); lat++; end
        prod = product8;
        tick();
    endtask

    logic [31:0] expQ[$];
    int          inCount;
    int          outCount;
    bit          abortStream;

    initial begin
        logic [7:0]  p4;
        logic [15:0] p8;
        int          lat;
        int          n;

        vecs[0] = '{4'hF, 4'hF, 1'b0, 8'hE1};
        vecs[1] = '{4'hD, 4'h5, 1'b1, 8'hF1};
        vecs[2] = '{4'h8, 4'h8, 1'b1, 8'h40};
        vecs[3] = '{4'h8, 4'h7, 1'b1, 8'hC8};
        vecs[4] = '{4'h6, 4'h7, 1'b0, 8'h2A};
        vecs[5] = '{4'h0, 4'h0, 1'b0, 8'h00};
        vecs[6] = '{4'hF, 4'hF, 1'b1, 8'h01};
        vecs[7] = '{4'h8, 4'h1, 1'b0, 8'h08};
        vecs[8] = '{4'h0, 4'hB, 1'b1, 8'h00};

        rstN = 1'b0; clr = 1'b0;
        inValid4 = 1'b0; a4 = '0; b4 = '0; signedMode4 = 1'b0; outReady4 = 1'b0;
        inValid8 = 1'b0; a8 = '0; b8 = '0; signedMode8 = 1'b0; outReady8 = 1'b0;
        tick();
        checkOutput("reset ready/valid/busy", {inReady4, outValid4, busy4}, 3'b100);
        checkOutput("reset product", product4, 8'h00);
        checkOutput("reset product w8", product8, 16'h0000);
        rstN = 1'b1;
        tick();

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            applyStimulus4(vecs[i].a, vecs[i].b, vecs[i].sm, p4, lat);
            checkOutput($sformatf("table product %0d", i), p4, vecs[i].expected);
            checkOutput($sformatf("table latency %0d", i), lat, 4);
            checkOutput($sformatf("table idle after handshake %0d", i),
                        {inReady4, outValid4, busy4}, 3'b100);
        end

        // Backpressure: hold result for 10 cycles
        a4 = 4'd6; b4 = 4'd7; signedMode4 = 1'b0; inValid4 = 1'b1; outReady4 = 1'b0;
        tick();
        inValid4 = 1'b0;
        lat = 0;
        while (!outValid4 && lat < 50) begin tick(); lat++; end
        checkOutput("backpressure latency", lat, 4);
        for (int i = 0; i < 10; i++) begin
            checkOutput("backpressure hold flags", {outValid4, inReady4, busy4}, 3'b101);
            checkOutput("backpressure hold product", product4, 8'h2A);
            tick();
        end
        outReady4 = 1'b1;
        tick();
        checkOutput("backpressure release", {inReady4, outValid4, busy4}, 3'b100);
        checkOutput("backpressure product kept", product4, 8'h2A);

        // Asynchronous reset mid-CALC
        a4 = 4'd5; b4 = 4'd5; signedMode4 = 1'b0; inValid4 = 1'b1;
        tick();
        inValid4 = 1'b0;
        tick();
        tick();
        #2 rstN = 1'b0;
        #1;
        checkOutput("async reset flags", {inReady4, outValid4, busy4}, 3'b100);
        checkOutput("async reset product", product4, 8'h00);
        rstN = 1'b1;
        tick();
        applyStimulus4(4'd3, 4'd4, 1'b0, p4, lat);
        checkOutput("after reset 3*4", p4, 8'h0C);

        // Synchronous clr mid-CALC
        a4 = 4'd5; b4 = 4'd5; signedMode4 = 1'b0; inValid4 = 1'b1;
        tick();
        inValid4 = 1'b0;
        tick();
        tick();
        clr = 1'b1;
        #1;
        checkOutput("clr waits for edge", {inReady4, busy4}, 2'b01);
        tick();
        clr = 1'b0;
        checkOutput("clr flags", {inReady4, outValid4, busy4}, 3'b100);
        checkOutput("clr product", product4, 8'h00);
        applyStimulus4(4'd3, 4'd4, 1'b0, p4, lat);
        checkOutput("after clr 3*4", p4, 8'h0C);

        // clr while holding a result in DONE
        a4 = 4'd6; b4 = 4'd7; inValid4 = 1'b1; outReady4 = 1'b0;
        tick();
        inValid4 = 1'b0;
        n = 0;
        while (!outValid4 && n < 50) begin tick(); n++; end
        checkOutput("done before clr", {outValid4, product4}, {1'b1, 8'h2A});
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checkOutput("clr in done", {inReady4, outValid4, product4}, {1'b1, 1'b0, 8'h00});

        // WIDTH=8 boundary cases
        applyStimulus8(8'hFF, 8'hFF, 1'b0, p8, lat);
        checkOutput("w8 255*255", p8, 16'hFE01);
        checkOutput("w8 latency", lat, 8);
        applyStimulus8(8'h80, 8'h80, 1'b1, p8, lat);
        checkOutput("w8 -128*-128", p8, 16'h4000);
        applyStimulus8(8'hFF, 8'h01, 1'b1, p8, lat);
        checkOutput("w8 -1*1", p8, 16'hFFFF);
        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra, rb;
            logic       rs;
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            applyStimulus8(ra, rb, rs, p8, lat);
            checkOutput("w8 random", p8, refProduct(8, 16'(ra), 16'(rb), rs));
        end

        // Exhaustive WIDTH=4 stream with random gaps on both sides
        inCount = 0; outCount = 0; abortStream = 0;
        fork
            begin : producer
                for (int sm = 0; sm < 2 && !abortStream; sm++) begin
                    for (int ai = 0; ai < 16 && !abortStream; ai++) begin
                        for (int bi = 0; bi < 16 && !abortStream; bi++) begin
                            bit acc;
                            int w;
                            while ($urandom_range(0, 2) == 0) begin
                                inValid4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
                                tick();
                            end
                            a4 = 4'(ai); b4 = 4'(bi); signedMode4 = 1'(sm); inValid4 = 1'b1;
                            w = 0;
                            do begin
                                acc = inReady4;
                                tick();
                                w++;
                            end while (!acc && w < 50);
                            if (!acc) begin
                                checkOutput("stream accept timeout", 32'(w), 32'(0));
                                abortStream = 1;
                            end else begin
                                expQ.push_back(refProduct(4, 16'(ai), 16'(bi), 1'(sm)));
                                inCount++;
                            end
                            inValid4 = 1'b0;
                        end
                    end
                end
            end
            begin : consumer
                int cyc;
                cyc = 0;
                while (outCount < 512 && cyc < 30000 && !(abortStream && expQ.size() == 0)) begin
                    outReady4 = ($urandom_range(0, 2) != 0);
                    if (outValid4 && outReady4) begin
                        if (expQ.size() == 0) begin
                            checkOutput("stream unexpected output", 32'(product4), 32'hFFFF_FFFF);
                        end else begin
                            checkOutput("stream product", 32'(product4), expQ.pop_front());
                        end
                        outCount++;
                    end
                    tick();
                    cyc++;
                end
            end
        join
        checkOutput("stream count in", inCount, 512);
        checkOutput("stream count out", outCount, 512);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
